// File: rtl/mem_fill_arbiter_pkg.sv
// Shared constants and state type for the memory fill arbiter.
package mem_arb_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);

  // Byte offset within a block: WPB words of 2 bytes each.
  localparam logic [ADDR_W-1:0] BLK_OFFSET_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// Cache-side and memory-side signals of the fill arbiter.
// slave = arbiter view, master = caches + memory view.
interface mem_fill_arbiter_if;
  import mem_arb_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_grant;
  logic              i_data_valid;
  logic              i_done;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_grant;
  logic              d_data_valid;
  logic              d_done;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done,
           word_idx, rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done,
           word_idx, rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_fill_arbiter_burst_ctr.sv
// Burst sequencing: issue counter drives WPB consecutive read addresses,
// receive counter tags returned words with their index.
module mem_burst_ctr
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic              iss_active,
  output logic [IDX_W-1:0]  idx,
  output logic              last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  logic [IDX_W-1:0] iss;
  logic [IDX_W-1:0] rcv;

  // Counters restart on start; issue stops after the last address, receive
  // advances on every qualified return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss        <= '0;
      rcv        <= '0;
      iss_active <= 1'b0;
    end else if (start) begin
      iss        <= '0;
      rcv        <= '0;
      iss_active <= 1'b1;
    end else begin
      if (iss_active) begin
        iss <= iss + IDX_W'(1);
        if (iss == LAST_IDX) iss_active <= 1'b0;
      end
      if (mem_valid) rcv <= rcv + IDX_W'(1);
    end
  end

  // Word address steps by 2 bytes; sum wraps modulo 2^ADDR_W.
  assign addr = base + (ADDR_W'(iss) << 1);
  assign idx  = rcv;
  assign last = mem_valid && (rcv == LAST_IDX);

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I/D cache miss traffic onto one pipelined memory port.
// Fixed priority D > I, non-preemptive, one idle cycle between transactions.
module mem_fill_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mem_fill_arbiter_if.slave  bus
);

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdata_q;
  logic              fill;
  logic              valid_in;
  logic              start;
  logic [ADDR_W-1:0] burst_addr;
  logic              iss_active;
  logic [IDX_W-1:0]  idx;
  logic              last;

  assign fill     = (state == I_FILL) || (state == D_FILL);
  // Returns outside a fill (idle, write, post-reset stragglers) are dropped here.
  assign valid_in = fill && bus.mem_valid;
  assign start    = (state == IDLE) && (bus.d_req ? !bus.d_wr : bus.i_req);

  mem_burst_ctr u_ctr (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_valid  (valid_in),
    .base       (base),
    .addr       (burst_addr),
    .iss_active (iss_active),
    .idx        (idx),
    .last       (last)
  );

  // State register and transaction latch, captured while arbitrating in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      base    <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (bus.d_req) begin
          base    <= bus.d_wr ? bus.d_addr : (bus.d_addr & ~BLK_OFFSET_MASK);
          wdata_q <= bus.d_wdata;
        end else if (bus.i_req) begin
          base <= bus.i_addr & ~BLK_OFFSET_MASK;
        end
      end
    end
  end

  // Next state and output steering; everything idles at 0.
  always_comb begin
    state_nxt        = state;
    bus.i_grant      = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_done       = 1'b0;
    bus.d_grant      = 1'b0;
    bus.d_data_valid = 1'b0;
    bus.d_done       = 1'b0;
    bus.word_idx     = '0;
    bus.rdata        = '0;
    bus.mem_en       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    case (state)
      IDLE: begin
        if (bus.d_req)      state_nxt = bus.d_wr ? D_WRITE : D_FILL;
        else if (bus.i_req) state_nxt = I_FILL;
      end
      I_FILL, D_FILL: begin
        bus.mem_en = iss_active;
        if (iss_active) bus.mem_addr = burst_addr;
        if (valid_in) begin
          bus.rdata    = bus.mem_rdata;
          bus.word_idx = idx;
        end
        if (state == I_FILL) begin
          bus.i_grant      = 1'b1;
          bus.i_data_valid = valid_in;
          bus.i_done       = last;
        end else begin
          bus.d_grant      = 1'b1;
          bus.d_data_valid = valid_in;
          bus.d_done       = last;
        end
        if (last) state_nxt = IDLE;
      end
      D_WRITE: begin
        bus.d_grant   = 1'b1;
        bus.d_done    = 1'b1;
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = base;
        bus.mem_wdata = wdata_q;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Randomized scoreboard bench for mem_fill_arbiter with a fixed-latency memory model.
module tb_mem_fill_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 3;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          first;
  } mreq_t;

  // kind: 0 = I fill word, 1 = D fill word, 2 = D write completion
  typedef struct {
    int          kind;
    int          idx;
    logic [15:0] data;
    bit          done;
  } del_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_fill_arbiter_if bus();
  mem_fill_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  mreq_t exp_mem[$];
  del_t  exp_del[$];
  int checks = 0, passes = 0;
  int cyc = 0, del_cnt = 0, last_en_cyc = 0;
  int i_gnt_cyc, i_done_cyc, d_gnt_cyc, d_done_cyc;
  bit stray = 1'b0;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  function automatic logic [63:0] outs();
    return {5'd0, bus.i_grant, bus.i_data_valid, bus.i_done, bus.d_grant, bus.d_data_valid,
            bus.d_done, bus.word_idx, bus.rdata, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic push_fill(input bit is_d, input logic [15:0] a);
    logic [15:0] b, ad;
    b = a & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      ad = b + 16'(2 * i);
      exp_mem.push_back('{1'b0, ad, 16'h0, i == 0});
      exp_del.push_back('{is_d ? 1 : 0, i, mem_fn(ad), i == 7});
    end
  endtask

  task automatic push_write(input logic [15:0] a, input logic [15:0] w);
    exp_mem.push_back('{1'b1, a, w, 1'b1});
    exp_del.push_back('{2, 0, 16'h0, 1'b1});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: read data for address a returns LAT-1 cycles after the request.
  logic        vp[LAT];
  logic [15:0] ap[LAT];
  initial begin
    for (int k = 0; k < LAT; k++) begin vp[k] = 1'b0; ap[k] = 16'h0; end
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      for (int k = LAT - 1; k > 0; k--) begin vp[k] = vp[k-1]; ap[k] = ap[k-1]; end
      vp[0] = bus.mem_en && !bus.mem_wr;
      ap[0] = bus.mem_addr;
      bus.mem_valid = vp[LAT-1] || stray;
      bus.mem_rdata = vp[LAT-1] ? mem_fn(ap[LAT-1]) : 16'($urandom);
    end
  end

  // Monitor: pops expected memory requests and deliveries whenever the DUT shows one.
  initial begin
    mreq_t m;
    del_t  d;
    logic [63:0] ev, av;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("grant_mutex", 64'(bus.i_grant & bus.d_grant), 64'd0);
        if (bus.mem_en) begin
          if (exp_mem.size() == 0) begin
            checks++;
            $display("FAIL unexpected_mem_req: got addr %h wr %b, expected none", bus.mem_addr, bus.mem_wr);
          end else begin
            m = exp_mem.pop_front();
            chk("mem_req", {31'd0, bus.mem_wr, bus.mem_addr, bus.mem_wr ? bus.mem_wdata : 16'h0},
                           {31'd0, m.wr, m.addr, m.wr ? m.wdata : 16'h0});
            if (!m.first) chk("burst_contiguous", 64'(cyc), 64'(last_en_cyc + 1));
            last_en_cyc = cyc;
          end
        end
        av = {41'd0, bus.i_data_valid, bus.d_data_valid, bus.i_done, bus.d_done, bus.word_idx, bus.rdata};
        if (bus.i_data_valid || bus.d_data_valid || bus.i_done || bus.d_done) begin
          del_cnt++;
          if (exp_del.size() == 0) begin
            checks++;
            $display("FAIL unexpected_delivery: got %h, expected none", av);
          end else begin
            d = exp_del.pop_front();
            ev = {41'd0, d.kind == 0, d.kind == 1, d.kind == 0 && d.done,
                  (d.kind == 1 && d.done) || d.kind == 2, 3'(d.idx), d.data};
            chk("delivery", av, ev);
          end
        end else begin
          chk("idle_rdata", av, 64'd0);
        end
      end
    end
  end

  task automatic drive_i(input logic [15:0] a, input int dly, input bit drop, input bit chk_lat);
    int n;
    repeat (dly) @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = a;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!bus.i_grant && n < 200);
    if (!bus.i_grant) timeout("i_grant_wait");
    if (chk_lat) chk("i_grant_latency", 64'(n), 64'd1);
    i_gnt_cyc = cyc;
    if (drop) bus.i_req = 1'b0;
    n = 0;
    while (!bus.i_done && n < 200) begin @(negedge clk); #2; n++; end
    if (!bus.i_done) timeout("i_done_wait");
    i_done_cyc = cyc;
    bus.i_req = 1'b0;
  endtask

  task automatic drive_d(input logic [15:0] a, input bit wr, input logic [15:0] w, input int dly,
                         input bit chk_lat);
    int n;
    repeat (dly) @(negedge clk);
    bus.d_req = 1'b1; bus.d_wr = wr; bus.d_addr = a; bus.d_wdata = w;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!bus.d_grant && n < 200);
    if (!bus.d_grant) timeout("d_grant_wait");
    if (chk_lat) chk("d_grant_latency", 64'(n), 64'd1);
    d_gnt_cyc = cyc;
    n = 0;
    while (!bus.d_done && n < 200) begin @(negedge clk); #2; n++; end
    if (!bus.d_done) timeout("d_done_wait");
    d_done_cyc = cyc;
    bus.d_req = 1'b0; bus.d_wr = 1'b0;
  endtask

  task automatic gap();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [15:0] a, b, w;
    int n, d0, typ, dl;
    bit wr;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    #1 rst = 1'b0;
    #2 chk("reset_outputs", outs(), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    gap();
    chk("idle_outputs", outs(), 64'd0);

    // Basic I fill from a mid-block address.
    push_fill(1'b0, 16'h0046);
    drive_i(16'h0046, 0, 1'b0, 1'b1);
    gap();

    // Simultaneous requests: D wins, I follows after one idle cycle.
    a = 16'($urandom); b = 16'($urandom);
    push_fill(1'b1, b); push_fill(1'b0, a);
    fork
      drive_d(b, 1'b0, 16'h0, 0, 1'b1);
      drive_i(a, 0, 1'b0, 1'b0);
    join
    chk("i_after_d_gap", 64'(i_gnt_cyc - d_done_cyc), 64'd2);
    gap();

    // D arrives mid I burst and waits.
    a = 16'($urandom); b = 16'($urandom);
    push_fill(1'b0, a); push_fill(1'b1, b);
    fork
      drive_i(a, 0, 1'b0, 1'b1);
      drive_d(b, 1'b0, 16'h0, 4, 1'b0);
    join
    chk("d_after_i_gap", 64'(d_gnt_cyc - i_done_cyc), 64'd2);
    gap();

    // Single-word write.
    push_write(16'h1234, 16'hBEEF);
    drive_d(16'h1234, 1'b1, 16'hBEEF, 0, 1'b1);
    chk("write_one_cycle", 64'(d_done_cyc), 64'(d_gnt_cyc));
    gap();

    // Top-of-memory block, request dropped after grant.
    push_fill(1'b0, 16'hFFF5);
    drive_i(16'hFFF5, 0, 1'b1, 1'b1);
    gap();

    // Reset after three returned words.
    a = 16'($urandom);
    push_fill(1'b0, a);
    bus.i_req = 1'b1; bus.i_addr = a;
    d0 = del_cnt; n = 0;
    while (del_cnt < d0 + 3 && n < 200) begin @(negedge clk); #3; n++; end
    if (del_cnt < d0 + 3) timeout("three_words_wait");
    rst = 1'b0;
    #1 chk("reset_mid_burst", outs(), 64'd0);
    exp_mem.delete(); exp_del.delete();
    bus.i_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1 stray = 1'b1;
    repeat (3) @(negedge clk);
    #1 stray = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    a = 16'($urandom);
    push_fill(1'b0, a);
    drive_i(a, 0, 1'b0, 1'b1);
    gap();

    // Random mix of single and overlapping transactions.
    for (int it = 0; it < 24; it++) begin
      typ = $urandom_range(0, 5);
      a = 16'($urandom); b = 16'($urandom); w = 16'($urandom);
      wr = 1'($urandom_range(0, 1));
      dl = $urandom_range(1, 6);
      case (typ)
        0: begin push_fill(1'b0, a); drive_i(a, 0, 1'($urandom_range(0, 1)), 1'b1); end
        1: begin push_fill(1'b1, b); drive_d(b, 1'b0, 16'h0, 0, 1'b1); end
        2: begin push_write(b, w); drive_d(b, 1'b1, w, 0, 1'b1); end
        3: begin
          if (wr) push_write(b, w); else push_fill(1'b1, b);
          push_fill(1'b0, a);
          fork
            drive_d(b, wr, w, 0, 1'b1);
            drive_i(a, 0, 1'b0, 1'b0);
          join
          chk("rand_i_after_d", 64'(i_gnt_cyc - d_done_cyc), 64'd2);
        end
        4: begin
          push_fill(1'b0, a);
          if (wr) push_write(b, w); else push_fill(1'b1, b);
          fork
            drive_i(a, 0, 1'b0, 1'b1);
            drive_d(b, wr, w, dl, 1'b0);
          join
          chk("rand_d_after_i", 64'(d_gnt_cyc - i_done_cyc), 64'd2);
        end
        default: begin
          push_fill(1'b1, b); push_fill(1'b0, a);
          fork
            drive_d(b, 1'b0, 16'h0, 0, 1'b1);
            drive_i(a, dl, 1'b0, 1'b0);
          join
          chk("rand_i_waits_d", 64'(i_gnt_cyc - d_done_cyc), 64'd2);
        end
      endcase
      gap();
    end

    repeat (10) @(negedge clk);
    chk("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
    chk("del_queue_drained", 64'(exp_del.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
